// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg
//   Shared definitions for the retirement monitor: number of instruction
//   classes, the 5-bit class enum, MIPS opcode/funct constants and the
//   classify() helper that maps a 32-bit instruction word to its class.
package mips_trace_pkg;

  localparam int NUM_CLASS = 17;
  localparam int CLASS_W   = 5;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ADD   = 5'd0,
    CLS_SUB   = 5'd1,
    CLS_AND   = 5'd2,
    CLS_OR    = 5'd3,
    CLS_SLT   = 5'd4,
    CLS_NOP   = 5'd5,
    CLS_SLL   = 5'd6,
    CLS_MULTU = 5'd7,
    CLS_MFHI  = 5'd8,
    CLS_MFLO  = 5'd9,
    CLS_ADDIU = 5'd10,
    CLS_LW    = 5'd11,
    CLS_SW    = 5'd12,
    CLS_BEQ   = 5'd13,
    CLS_BNE   = 5'd14,
    CLS_J     = 5'd15,
    CLS_OTHER = 5'd16
  } ret_class_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_ADDIU   = 6'd9;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_SW      = 6'd43;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  function automatic ret_class_e classify(input logic [31:0] instr);
    ret_class_e cls;
    logic [5:0] op;
    logic [5:0] fn;
    op  = instr[31:26];
    fn  = instr[5:0];
    cls = CLS_OTHER;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_ADD:   cls = CLS_ADD;
        FN_SUB:   cls = CLS_SUB;
        FN_AND:   cls = CLS_AND;
        FN_OR:    cls = CLS_OR;
        FN_SLT:   cls = CLS_SLT;
        // The canonical NOP is the all-zero word; any other funct-0 word is a real shift.
        FN_SLL:   cls = (instr == 32'd0) ? CLS_NOP : CLS_SLL;
        FN_MULTU: cls = CLS_MULTU;
        FN_MFHI:  cls = CLS_MFHI;
        FN_MFLO:  cls = CLS_MFLO;
        default:  cls = CLS_OTHER;
      endcase
    end else begin
      case (op)
        OP_ADDIU: cls = CLS_ADDIU;
        OP_LW:    cls = CLS_LW;
        OP_SW:    cls = CLS_SW;
        OP_BEQ:   cls = CLS_BEQ;
        OP_BNE:   cls = CLS_BNE;
        OP_J:     cls = CLS_J;
        default:  cls = CLS_OTHER;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous first-word-fall-through FIFO for retirement trace entries.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     push, push_data     write request and data; a push while full is
//                         accepted only if a pop happens in the same cycle
//     rd_valid, rd_ready  read handshake; rd_data shows the head whenever
//                         rd_valid=1 and a pop happens on rd_valid && rd_ready
//     rd_data             head entry (zero when empty)
//     level, full, empty  occupancy, registered
//   No bypass: an entry pushed into an empty FIFO appears one cycle later.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign rd_valid = !empty;
  assign level    = level_q;

  assign do_pop  = rd_ready && !empty;
  // Full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset, so the head is masked while empty to keep outputs at 0.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mips_retire_monitor.sv
// mips_retire_monitor
//   Retirement monitor beside the writeback stage. Classifies each retired
//   instruction, keeps saturating per-class / retired / cycle counters and
//   buffers a {pc, class} trace in a FWFT FIFO.
//   Ports:
//     clk, rst                       clock, asynchronous active-low reset
//     ret_valid, ret_pc, ret_instr   retirement strobe and instruction info
//     cnt_clear                      synchronous clear of counters and trace_ovf
//     cnt_sel, cnt_rdata             class select and registered count readout
//     retired_cnt, cycle_cnt         total retirements, cycles since reset/clear
//     trace_valid/ready/pc/class     trace drain port
//     trace_level, trace_ovf         FIFO occupancy, sticky drop flag
//   Trace handshake: trace_valid/trace_pc/trace_class are stable while
//   trace_valid=1; an entry leaves on a rising edge with trace_valid && trace_ready,
//   and trace_ready is ignored while trace_valid=0.
module mips_retire_monitor
  import mips_trace_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ret_valid,
  input  logic [PC_W-1:0]              ret_pc,
  input  logic [31:0]                  ret_instr,
  input  logic                         cnt_clear,
  input  logic [4:0]                   cnt_sel,
  output logic [CNT_W-1:0]             cnt_rdata,
  output logic [CNT_W-1:0]             retired_cnt,
  output logic [CNT_W-1:0]             cycle_cnt,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [PC_W-1:0]              trace_pc,
  output logic [4:0]                   trace_class,
  output logic [$clog2(TRACE_DEPTH):0] trace_level,
  output logic                         trace_ovf
);

  localparam int TW = PC_W + CLASS_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ret_class_e       ret_cls;
  logic [CNT_W-1:0] cls_cnt [NUM_CLASS];
  logic [CNT_W-1:0] sel_cnt;
  logic [TW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             trace_drop;

  assign ret_cls = classify(ret_instr);

  trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_valid),
    .push_data ({ret_pc, ret_cls}),
    .rd_valid  (trace_valid),
    .rd_ready  (trace_ready),
    .rd_data   (head),
    .level     (trace_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_pc    = head[TW-1:CLASS_W];
  assign trace_class = head[CLASS_W-1:0];

  // Entry is lost only when full and the head is not leaving this cycle.
  assign trace_drop = ret_valid && fifo_full && !(trace_ready && !fifo_empty);

  // Readout mux; unused selects (>= NUM_CLASS) read as zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (cnt_sel == 5'(i)) sel_cnt = cls_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLASS; i++) cls_cnt[i] <= '0;
      retired_cnt <= '0;
      cycle_cnt   <= '0;
      cnt_rdata   <= '0;
      trace_ovf   <= '0;
    end else begin
      // cnt_rdata always captures the value before this edge's update.
      cnt_rdata <= sel_cnt;
      if (cnt_clear) begin
        for (int i = 0; i < NUM_CLASS; i++) cls_cnt[i] <= '0;
        retired_cnt <= '0;
        cycle_cnt   <= '0;
        trace_ovf   <= 1'b0;
      end else begin
        cycle_cnt <= sat_inc(cycle_cnt);
        if (ret_valid) begin
          retired_cnt <= sat_inc(retired_cnt);
          for (int i = 0; i < NUM_CLASS; i++) begin
            if (ret_cls == ret_class_e'(i)) cls_cnt[i] <= sat_inc(cls_cnt[i]);
          end
        end
        if (trace_drop) trace_ovf <= 1'b1;
      end
    end
  end

endmodule
